// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Multiply/divide results are computed at start and committed after a fixed busy window.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  HILO_typeE,
    input  logic [31:0] R1E,
    input  logic [31:0] R2E,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HILO_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi, lo, res_hi, res_lo;
    logic [CNT_W-1:0] cnt;

    logic        req_act, is_md, is_mult;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, mag_q, mag_r;
    logic [31:0] sdiv_q, sdiv_r, udiv_q, udiv_r;
    logic [31:0] next_hi, next_lo;

    // X or Z on Req must read as "no flush".
    assign req_act = (Req === 1'b1);
    assign is_md   = (HILO_typeE >= 4'd1) && (HILO_typeE <= 4'd4);
    assign is_mult = (HILO_typeE == 4'd1) || (HILO_typeE == 4'd2);
    assign Busy    = (cnt != '0);
    assign Start   = is_md && !req_act && !Busy;

    always_comb begin
        HILO_out = 32'd0;
        if (HILO_typeE == 4'd5) HILO_out = hi;
        else if (HILO_typeE == 4'd6) HILO_out = lo;
    end

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        prod_s = {{32{R1E[31]}}, R1E} * {{32{R2E[31]}}, R2E};
        prod_u = {32'd0, R1E} * {32'd0, R2E};
        abs_a  = R1E[31] ? (32'd0 - R1E) : R1E;
        abs_b  = R2E[31] ? (32'd0 - R2E) : R2E;
        mag_q  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        mag_r  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        sdiv_q = (R1E[31] ^ R2E[31]) ? (32'd0 - mag_q) : mag_q;
        sdiv_r = R1E[31] ? (32'd0 - mag_r) : mag_r;
        udiv_q = (R2E == 32'd0) ? 32'd0 : R1E / R2E;
        udiv_r = (R2E == 32'd0) ? 32'd0 : R1E % R2E;

        next_hi = hi;
        next_lo = lo;
        case (HILO_typeE)
            4'd1: begin next_hi = prod_s[63:32]; next_lo = prod_s[31:0]; end
            4'd2: begin next_hi = prod_u[63:32]; next_lo = prod_u[31:0]; end
            4'd3: if (R2E != 32'd0) begin next_hi = sdiv_r; next_lo = sdiv_q; end
            4'd4: if (R2E != 32'd0) begin next_hi = udiv_r; next_lo = udiv_q; end
            default: ;
        endcase
    end

    // A zero divisor latches the current HI/LO, which cannot change while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            cnt    <= '0;
        end else if (Busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (Start) begin
            res_hi <= next_hi;
            res_lo <= next_lo;
            cnt    <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (!req_act) begin
            if (HILO_typeE == 4'd7) hi <= R1E;
            if (HILO_typeE == 4'd8) lo <= R1E;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, flush/reset sequences,
// and random operations checked against an arithmetic HI/LO model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  HILO_typeE;
    logic [31:0] R1E, R2E;
    logic        Start, Busy;
    logic [31:0] HILO_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Req(Req), .HILO_typeE(HILO_typeE),
        .R1E(R1E), .R2E(R2E), .Start(Start), .Busy(Busy), .HILO_out(HILO_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural HI/LO after an op, using plain wide arithmetic.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = longint'(sa * sb); model_hi = p[63:32]; model_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; model_hi = p[63:32]; model_lo = p[31:0]; end
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                model_lo = q[31:0]; model_hi = r[31:0];
            end
            4'd4: if (b != 0) begin model_lo = a / b; model_hi = a % b; end
            4'd7: model_hi = a;
            4'd8: model_lo = a;
            default: ;
        endcase
    endtask

    task automatic read_check(input string name);
        HILO_typeE = 4'd5; #1;
        check({name, " mfhi"}, HILO_out, model_hi);
        HILO_typeE = 4'd6; #1;
        check({name, " mflo"}, HILO_out, model_lo);
        HILO_typeE = 4'd0;
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] v, input string name);
        HILO_typeE = op; R1E = v; #1;
        check({name, " start_low"}, {31'd0, Start}, 32'd0);
        tick();
        HILO_typeE = 4'd0;
        check({name, " busy_low"}, {31'd0, Busy}, 32'd0);
        ref_op(op, v, 32'd0);
        read_check(name);
    endtask

    // Issue a mult/div, count busy cycles, verify old LO during the window and the commit.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input int req_at, input logic [3:0] stray_op,
                          input string name);
        logic [31:0] old_lo;
        int n;
        old_lo = model_lo;
        HILO_typeE = op; R1E = a; R2E = b; #1;
        check({name, " start"}, {31'd0, Start}, 32'd1);
        tick();
        HILO_typeE = 4'd6; #1;
        check({name, " old_lo"}, HILO_out, old_lo);
        HILO_typeE = stray_op; R1E = 32'hDEAD_BEEF; R2E = 32'h3;
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            if (n == req_at) Req = 1'b1;
            n++;
            tick();
        end
        HILO_typeE = 4'd0;
        Req = 1'b0;
        check({name, " busy_cycles"}, n, exp_cycles);
        ref_op(op, a, b);
        read_check(name);
    endtask

    initial begin
        vecs[0] = '{"mult",     4'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{"multu",    4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{"div",      4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu",     4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4] = '{"div_ovf",  4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5] = '{"multu_max",4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

        reset = 1'b1; Req = 1'b0; HILO_typeE = 4'd0; R1E = 32'd0; R2E = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset start", {31'd0, Start}, 32'd0);
        read_check("reset");

        // Directed table; each start lands in the first non-busy cycle of the previous op.
        for (int i = 0; i < 6; i++) begin
            run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles, -1, 4'd0, vecs[i].name);
            check({vecs[i].name, " tbl_hi"}, model_hi, vecs[i].exp_hi);
            check({vecs[i].name, " tbl_lo"}, model_lo, vecs[i].exp_lo);
        end

        move(4'd7, 32'h11, "mthi");
        move(4'd8, 32'h22, "mtlo");
        run_md(4'd3, 32'd1234, 32'd0, 10, -1, 4'd0, "div0");
        check("div0 hi kept", model_hi, 32'h11);
        check("div0 lo kept", model_lo, 32'h22);

        // Flush on the start cycle: no start, nothing changes.
        Req = 1'b1; HILO_typeE = 4'd1; R1E = 32'd9; R2E = 32'd9; #1;
        check("flush start", {31'd0, Start}, 32'd0);
        tick();
        check("flush busy", {31'd0, Busy}, 32'd0);
        HILO_typeE = 4'd7; tick();
        Req = 1'b0; HILO_typeE = 4'd0;
        check("flush busy2", {31'd0, Busy}, 32'd0);
        read_check("flush");

        run_md(4'd3, 32'd100, 32'hFFFF_FFF9, 10, 3, 4'd0, "req_mid_div");
        run_md(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, -1, 4'd8, "stray_mtlo");
        run_md(4'd2, 32'h0000_FFFF, 32'h0001_0001, 5, -1, 4'd3, "stray_div");

        // Reset mid-divide aborts the op and clears HI/LO.
        HILO_typeE = 4'd4; R1E = 32'd50; R2E = 32'd7; tick();
        HILO_typeE = 4'd0; tick(); tick(); tick();
        check("mid busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid busy", {31'd0, Busy}, 32'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        read_check("rst_mid");

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(1, 8));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                3: a = -a;
                default: ;
            endcase
            if (op == 4'd5 || op == 4'd6) read_check("rnd_read");
            else if (op >= 4'd7) move(op, a, "rnd_move");
            else run_md(op, a, b, (op <= 4'd2) ? 5 : 10, -1, 4'd0, "rnd_md");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
